// File: rtl/serial_reorder_buf_pkg.sv
// Shared types for the serial FFT commutator reorder buffer: permutation modes
// and the default sample width.
package serial_reorder_buf_pkg;

    localparam int NB_DEFAULT = 16;

    typedef enum logic [1:0] {
        MODE_DEINT  = 2'd0,
        MODE_BITREV = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

endpackage

// File: rtl/serial_reorder_perm.sv
// Combinational read-address permutation for one block index k:
// even/odd deinterleave, bit reversal, or pass-through.
module serial_reorder_perm
    import serial_reorder_buf_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [LOG2N-1:0] k,
    input  mode_t            mode,
    output logic [LOG2N-1:0] addr
);

    always_comb begin
        addr = k;
        case (mode)
            MODE_DEINT:  addr = {k[LOG2N-2:0], k[LOG2N-1]};
            MODE_BITREV: begin
                for (int unsigned i = 0; i < LOG2N; i++) begin
                    addr[i] = k[LOG2N-1-i];
                end
            end
            default:     addr = k;
        endcase
    end

endmodule

// File: rtl/serial_reorder_buf.sv
// Ping-pong reorder buffer: writes block b into one bank while block b-1 is
// read back permuted from the other. Optional drain port: SERIAL_REORDER_DRAIN_EN.
module serial_reorder_buf
    import serial_reorder_buf_pkg::*;
#(
    parameter int NB    = NB_DEFAULT,
    parameter int LOG2N = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    input  logic [NB-1:0] in_data,
`ifdef SERIAL_REORDER_DRAIN_EN
    input  logic          drain,
`endif
    output logic          out_valid,
    output logic [NB-1:0] out_data,
    output logic          out_first
);

    localparam int N = 1 << LOG2N;

    logic [NB-1:0]    mem [2][N];
    mode_t            bmode [2];
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] raddr;
    logic             wbank;
    logic             rb;
    logic [1:0]       full;
    logic             wr_en;
    logic             drain_en;
    logic             rd_en;
    logic             last;

    assign rb    = ~wbank;
    assign wr_en = in_valid & ~start;
    assign last  = (wcnt == '1);

`ifdef SERIAL_REORDER_DRAIN_EN
    assign drain_en = drain & ~in_valid & ~start;
`else
    assign drain_en = 1'b0;
`endif

    // Read index is the write counter itself; only the bank differs.
    assign rd_en = (wr_en | drain_en) & full[rb];

    serial_reorder_perm #(.LOG2N(LOG2N)) u_perm (
        .k    (wcnt),
        .mode (bmode[rb]),
        .addr (raddr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wbank][wcnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            full      <= '0;
            bmode[0]  <= MODE_DEINT;
            bmode[1]  <= MODE_DEINT;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_data  <= '0;
        end else if (start) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            full      <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_first <= rd_en & (wcnt == '0);
            if (rd_en) begin
                out_data <= mem[rb][raddr];
            end
            if (wr_en && wcnt == '0) begin
                bmode[wbank] <= mode_t'(mode);
            end
            if (wr_en || rd_en) begin
                wcnt <= wcnt + LOG2N'(1);
            end
            // Read and write banks differ, so clear and set never collide.
            if (rd_en && last) begin
                full[rb] <= 1'b0;
            end
            if (wr_en && last) begin
                full[wbank] <= 1'b1;
                wbank       <= ~wbank;
            end
        end
    end

endmodule

// File: tb/tb_serial_reorder_buf.sv
// Self-checking bench for serial_reorder_buf against a block-level reference
// model; covers the drain port when SERIAL_REORDER_DRAIN_EN is defined.
module tb_serial_reorder_buf;

    localparam int NB    = 16;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic [NB-1:0] in_data = '0;
    logic          drain = 1'b0;
    logic          out_valid;
    logic [NB-1:0] out_data;
    logic          out_first;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one completed block awaiting playback plus the block being collected.
    int            pend [N];
    int            cur  [N];
    bit            pend_v;
    int            pend_mode;
    int            cur_mode;
    int            cnt;
    bit            exp_valid;
    bit            exp_first;
    logic [NB-1:0] exp_data;

    always #5 clk = ~clk;

    serial_reorder_buf #(.NB(NB), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef SERIAL_REORDER_DRAIN_EN
        .drain     (drain),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_first (out_first)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int perm_idx(input int j, input int m);
        int r;
        if (m == 0) return (j < N/2) ? 2*j : 2*(j - N/2) + 1;
        if (m == 1) begin
            r = 0;
            for (int b = 0; b < LOG2N; b++) if (((j >> b) & 1) != 0) r |= 1 << (LOG2N-1-b);
            return r;
        end
        return j;
    endfunction

    task automatic model_reset();
        cnt = 0; pend_v = 0; exp_valid = 0; exp_first = 0; exp_data = '0;
    endtask

    task automatic model_step(input bit v, input int d, input int m, input bit st, input bit dr);
        bit adv;
        if (st) begin
            cnt = 0; pend_v = 0; exp_valid = 0; exp_first = 0;
            return;
        end
        adv = v || (dr && pend_v);
        if (adv && pend_v) begin
            exp_valid = 1;
            exp_first = (cnt == 0);
            exp_data  = NB'(pend[perm_idx(cnt, pend_mode)]);
        end else begin
            exp_valid = 0;
            exp_first = 0;
        end
        if (v) begin
            cur[cnt] = d;
            if (cnt == 0) cur_mode = m;
        end
        if (adv) begin
            if (pend_v && cnt == N-1) pend_v = 0;
            if (v && cnt == N-1) begin
                pend = cur; pend_mode = cur_mode; pend_v = 1;
            end
            cnt = (cnt + 1) % N;
        end
    endtask

    task automatic step(input bit v, input int d, input int m, input bit st, input bit dr);
        in_valid = v; in_data = NB'(d); mode = 2'(m); start = st; drain = dr;
        @(posedge clk);
`ifdef SERIAL_REORDER_DRAIN_EN
        model_step(v, d, m, st, dr);
`else
        model_step(v, d, m, st, 1'b0);
`endif
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_first", 32'(out_first), 32'(exp_first));
        check("out_data",  32'(out_data),  32'(exp_data));
    endtask

    initial begin
        model_reset();
        pend_mode = 0; cur_mode = 0;
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_first", 32'(out_first), 32'd0);
        check("reset_data",  32'(out_data),  32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Deinterleave, continuous stream
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0);
        step(1, 0, 0, 1, 0);

        // Bit-reverse; mode flips to bypass mid block 2 and must be ignored
        for (int i = 0; i < 24; i++) step(1, i, (i >= 11) ? 2 : 1, 0, 0);
        step(0, 0, 0, 1, 0);

        // Same stream with gaps every other cycle
        for (int i = 0; i < 16; i++) begin
            step(1, i, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end

        // start mid-stream discards buffered data
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 200 + i, 0, 0, 0);
        step(1, 999, 0, 1, 0);
        for (int i = 100; i < 116; i++) step(1, i, 0, 0, 0);

        // Async reset mid-block
        for (int i = 0; i < 5; i++) step(1, 50 + i, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_first", 32'(out_first), 32'd0);
        check("async_rst_data",  32'(out_data),  32'd0);
        model_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0);

`ifdef SERIAL_REORDER_DRAIN_EN
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
